// File: rtl/csa_accum_if.sv
// csa_accum_if: operand/result handshake bundle for csa_accum (out_ovf present only with CSA_ACCUM_OVF_EN)
interface csa_accum_if #(parameter int WIDTH = 23);
  logic in_valid, in_ready, in_last, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_sum;
`ifdef CSA_ACCUM_OVF_EN
  logic out_ovf;
  modport master (output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_sum, out_ovf);
  modport slave (input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_sum, out_ovf);
`else
  modport master (output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_sum);
  modport slave (input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_sum);
`endif
endinterface

// File: rtl/csa_accum.sv
// csa_accum: carry-save batch accumulator with chunked carry-propagate resolve; CSA_ACCUM_OVF_EN adds sticky out_ovf
module csa_accum #(
  parameter int WIDTH = 23,
  parameter int CHUNK = 8
) (
  input logic clk,
  input logic rst_n,
  csa_accum_if.slave bus
);
  localparam int NCH = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LW = WIDTH - (NCH - 1) * CHUNK;
  localparam int JW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});
  typedef enum logic [1:0] {ACC, RESOLVE, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d, c_q, c_d, res_q, res_d, cy;
  logic [JW-1:0] j_q, j_d;
  logic cin_q, cin_d, xfer, last_ch, cout;
  logic [CHUNK-1:0] s_ch, c_ch;
  logic [CHUNK:0] t;
  int sh;
`ifdef CSA_ACCUM_OVF_EN
  logic ovf_q, ovf_d;
`endif
  assign xfer = bus.in_valid && bus.in_ready;
  assign last_ch = int'(j_q) == NCH - 1;
  assign cy = (s_q & c_q) | (s_q & bus.in_data) | (c_q & bus.in_data);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      s_q <= '0;
      c_q <= '0;
      res_q <= '0;
      j_q <= '0;
      cin_q <= 1'b0;
`ifdef CSA_ACCUM_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      c_q <= c_d;
      res_q <= res_d;
      j_q <= j_d;
      cin_q <= cin_d;
`ifdef CSA_ACCUM_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q == ACC     ? (xfer && bus.in_last ? RESOLVE : ACC) :
              state_q == RESOLVE ? (last_ch ? DONE : RESOLVE) :
                                   (bus.out_ready ? ACC : DONE);
  end
  always_comb begin
    bus.in_ready = rst_n && state_q == ACC;
    bus.out_valid = rst_n && state_q == DONE;
    bus.out_sum = rst_n ? res_q : '0;
`ifdef CSA_ACCUM_OVF_EN
    bus.out_ovf = rst_n && ovf_q;
`endif
  end
  always_comb begin
    sh = int'(j_q) * CHUNK;
    s_ch = CHUNK'(s_q >> sh);
    c_ch = CHUNK'(c_q >> sh);
    t = {1'b0, s_ch} + {1'b0, c_ch} + (CHUNK+1)'(cin_q);
    cout = last_ch ? t[LW] : t[CHUNK];
    s_d = s_q;
    c_d = c_q;
    res_d = res_q;
    j_d = j_q;
    cin_d = cin_q;
`ifdef CSA_ACCUM_OVF_EN
    ovf_d = ovf_q;
`endif
    if (xfer) begin
      s_d = s_q ^ c_q ^ bus.in_data;
      c_d = cy << 1;
`ifdef CSA_ACCUM_OVF_EN
      ovf_d = ovf_q | cy[WIDTH-1];
`endif
      j_d = bus.in_last ? '0 : j_q;
      cin_d = bus.in_last ? 1'b0 : cin_q;
    end
    if (state_q == RESOLVE) begin
      res_d = (res_q & ~(MASK << sh)) | (WIDTH'(t[CHUNK-1:0]) << sh);
      j_d = last_ch ? '0 : j_q + 1'b1;
      cin_d = cout;
`ifdef CSA_ACCUM_OVF_EN
      ovf_d = ovf_q | (last_ch && cout);
`endif
    end
    if (state_q == DONE && bus.out_ready) begin
      s_d = '0;
      c_d = '0;
`ifdef CSA_ACCUM_OVF_EN
      ovf_d = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_csa_accum.sv
// tb_csa_accum: table, corner-case and random-batch checks of csa_accum against an arithmetic sum model
module tb_csa_accum;
  localparam int W = 23, C = 8, NCH = 3;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  csa_accum_if #(.WIDTH(W)) b();
  csa_accum_if #(.WIDTH(8)) b8();
  csa_accum #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  csa_accum #(.WIDTH(8), .CHUNK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  int n_chk = 0, n_fail = 0;
  typedef struct {
    int n;
    logic [W-1:0] ops [4];
    logic [W-1:0] sum;
    bit ovf;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ovf_now();
`ifdef CSA_ACCUM_OVF_EN
    return b.out_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic send(input logic [W-1:0] d, input bit l);
    int n = 0;
    b.in_valid = 1; b.in_data = d; b.in_last = l;
    while (!b.in_ready && n < 200) begin @(negedge clk); n++; end
    check("send_ready", b.in_ready, 1);
    @(negedge clk);
    b.in_valid = 0;
  endtask

  task automatic get_result(input bit rnd, output logic [W-1:0] s, output bit o, output int k);
    k = 0;
    while (!b.out_valid && k < 100) begin
      b.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      k++;
    end
    b.out_ready = 0;
    check("result_valid", b.out_valid, 1);
    s = b.out_sum;
    o = ovf_now();
    if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
    b.out_ready = 1;
    @(negedge clk);
    b.out_ready = 0;
  endtask

  task automatic run_batch(input logic [W-1:0] q [$], input bit rnd, output logic [W-1:0] s, output bit o, output int k);
    foreach (q[i]) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin b.out_ready = 1'($urandom_range(0, 1)); @(negedge clk); end
      send(q[i], i == q.size() - 1);
    end
    get_result(rnd, s, o, k);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q [$];
    logic [W-1:0] s, hold;
    bit o, seen;
    int k;
    longint tot;
    b.in_valid = 0; b.in_data = '0; b.in_last = 0; b.out_ready = 0;
    b8.in_valid = 0; b8.in_data = '0; b8.in_last = 0; b8.out_ready = 0;
    vt[0] = '{1, '{23'h000005, 0, 0, 0}, 23'h000005, 0};
    vt[1] = '{3, '{23'h7FFFFF, 23'h000001, 23'h000001, 0}, 23'h000001, 1};
    vt[2] = '{2, '{23'h400000, 23'h400000, 0, 0}, 23'h000000, 1};
    vt[3] = '{4, '{23'h1, 23'h2, 23'h3, 23'h4}, 23'h00000A, 0};
    vt[4] = '{1, '{23'h7FFFFF, 0, 0, 0}, 23'h7FFFFF, 0};
    vt[5] = '{2, '{23'h0000FF, 23'h000001, 0, 0}, 23'h000100, 0};
    vt[6] = '{2, '{23'h00FFFF, 23'h000001, 0, 0}, 23'h010000, 0};
    vt[7] = '{4, '{23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF}, 23'h7FFFFC, 1};
    @(negedge clk);
    check("rst_in_ready", b.in_ready, 0);
    check("rst_out_valid", b.out_valid, 0);
    check("rst_out_sum", b.out_sum, 0);
    check("rst_ovf", ovf_now(), 0);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_ready", b.in_ready, 1);
    check("w8_ready", b8.in_ready, 1);
    b8.in_valid = 1; b8.in_data = 8'hFF; b8.in_last = 0;
    @(negedge clk);
    b8.in_data = 8'h01; b8.in_last = 1;
    @(negedge clk);
    b8.in_valid = 0;
    check("w8_not_yet", b8.out_valid, 0);
    @(negedge clk);
    check("w8_valid", b8.out_valid, 1);
    check("w8_sum", b8.out_sum, 8'h00);
`ifdef CSA_ACCUM_OVF_EN
    check("w8_ovf", b8.out_ovf, 1);
`endif
    b8.out_ready = 1;
    @(negedge clk);
    b8.out_ready = 0;
    check("w8_released", b8.out_valid, 0);
    for (int v = 0; v < 8; v++) begin
      q = {};
      for (int i = 0; i < vt[v].n; i++) q.push_back(vt[v].ops[i]);
      run_batch(q, 0, s, o, k);
      check($sformatf("vec%0d_sum", v), s, vt[v].sum);
      check($sformatf("vec%0d_latency", v), k, NCH);
`ifdef CSA_ACCUM_OVF_EN
      check($sformatf("vec%0d_ovf", v), o, vt[v].ovf);
`endif
      check($sformatf("vec%0d_idle_ready", v), b.in_ready, 1);
    end
    send(23'h00ABCD, 0);
    send(23'h001111, 1);
    k = 0;
    while (!b.out_valid && k < 20) begin @(negedge clk); k++; end
    check("bp_valid", b.out_valid, 1);
    hold = b.out_sum;
    check("bp_sum", hold, 23'h00BCDE);
    repeat (5) begin
      @(negedge clk);
      check("bp_stable", b.out_sum, hold);
      check("bp_in_ready", b.in_ready, 0);
      check("bp_out_valid", b.out_valid, 1);
    end
    b.in_valid = 1; b.in_data = 23'h1; b.in_last = 1;
    @(negedge clk);
    b.in_valid = 0;
    check("bp_ignored_valid", b.out_sum, hold);
    b.out_ready = 1;
    @(negedge clk);
    b.out_ready = 0;
    check("bp_release_ready", b.in_ready, 1);
    check("bp_release_valid", b.out_valid, 0);
    send(23'h000055, 1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (6) begin @(negedge clk); seen |= b.out_valid; end
    check("rst_abort", seen, 0);
    q = {23'h000003};
    run_batch(q, 0, s, o, k);
    check("rst_after_sum", s, 23'h000003);
    for (int r = 0; r < 25; r++) begin
      q = {};
      tot = 0;
      for (int i = 0; i < $urandom_range(1, 50); i++) begin
        q.push_back(W'($urandom));
        tot += longint'(q[i]);
      end
      run_batch(q, 1, s, o, k);
      check($sformatf("rand%0d_sum", r), s, W'(tot % (64'd1 << W)));
`ifdef CSA_ACCUM_OVF_EN
      check($sformatf("rand%0d_ovf", r), o, tot >= (64'd1 << W));
`endif
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csa_accum.md
CSA_ACCUM -- requirements
Module: csa_accum

Interface
REQ-001 Parameter WIDTH, default 23, operand and result width in bits; WIDTH >= 2.
REQ-002 Parameter CHUNK, default 8, bits resolved per carry-propagate cycle; 1 <= CHUNK <= WIDTH.
REQ-003 Derived constant NCH = ceil(WIDTH/CHUNK), the number of resolve cycles.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  operand present on in_data.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 in_data  input  WIDTH  operand to add.
REQ-009 in_last  input  1  marks the final operand of a batch; qualified by the handshake.
REQ-010 out_valid  output  1  result present on out_sum.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_sum  output  WIDTH  batch sum modulo 2^WIDTH.
REQ-013 out_ovf  output  1  present only when CSA_ACCUM_OVF_EN is defined; batch sum >= 2^WIDTH.

Function
REQ-014 Internal state comprises the WIDTH-bit redundant registers S and C, plus an FSM with states ACC, RESOLVE and DONE.
REQ-015 An operand transfer occurs on an edge where in_valid and in_ready are both 1; in_ready SHALL equal (state == ACC).
REQ-016 In ACC, each transfer SHALL update S and C with a bitwise 3:2 compression of S, C and in_data: S gets the sum bits and C gets the carry bits shifted left by one, with bit 0 = 0; the carry out of bit WIDTH-1 is discarded.
REQ-017 With no transfer, S and C SHALL hold.
REQ-018 A transfer with in_last=1 SHALL move the FSM to RESOLVE with chunk index 0 and carry-in 0.
REQ-019 In RESOLVE, each cycle SHALL add chunk j of S, chunk j of C and the carry-in; it writes the chunk result into the result register, latches the chunk carry-out and increments j.
REQ-020 The last chunk SHALL be WIDTH - (NCH-1)*CHUNK bits wide.
REQ-021 After NCH resolve cycles, the FSM SHALL enter DONE.
REQ-022 out_valid SHALL be 1 exactly in DONE, so it rises NCH edges after the edge that accepts in_last.
REQ-023 In DONE, out_sum and out_ovf SHALL be held stable until the edge where out_ready=1.
REQ-024 On that edge, the block SHALL clear S, C and the overflow flag and return to ACC, with in_ready=1 on the next cycle.
REQ-025 out_ready while out_valid=0, and in_valid while in_ready=0, SHALL be ignored.
REQ-026 A batch of one operand with in_last=1 SHALL produce that operand unchanged.
REQ-027 Back-to-back batches SHALL incur exactly one idle cycle between the out_valid/out_ready edge and the next transfer.

Reset
REQ-028 On an edge with rst_n=0, the block SHALL set FSM=ACC, S=0, C=0, result=0, chunk index=0, carry-in=0 and overflow flag=0.
REQ-029 During that reset cycle, in_ready, out_valid and out_ovf SHALL be 0, and out_sum SHALL be 0.
REQ-030 Reset asserted during ACC, RESOLVE or DONE SHALL abort the batch with no partial result emitted.

Configuration
REQ-031 The macro CSA_ACCUM_OVF_EN is defined: out_ovf exists, and a sticky flag SHALL be set by any nonzero carry discarded in REQ-016 or by a nonzero carry-out of the final resolve chunk.
REQ-032 The macro CSA_ACCUM_OVF_EN is undefined: the out_ovf port and the sticky flag are absent, and all other behaviour is identical.

Verification
REQ-033 WIDTH=23, CHUNK=8: a single operand 0x000005 with in_last -> out_valid 3 edges later, out_sum=0x000005, out_ovf=0.
REQ-034 WIDTH=23, CHUNK=8: operands 0x7FFFFF, 0x000001, 0x000001 (last on the third) -> out_sum=0x000001, out_ovf=1 (macro defined).
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_sum stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 on the next cycle.
REQ-036 Reset mid-RESOLVE: drop rst_n for 1 cycle -> out_valid never rises for that batch; a following batch of 0x000003 -> out_sum=0x000003.
REQ-037 WIDTH=8, CHUNK=8: operands 0xFF, 0x01 -> out_sum=0x00, out_ovf=1, out_valid 1 edge after last is accepted.
REQ-038 Random batches of 1 to 50 operands with random in_valid and out_ready gaps -> out_sum equals the reference sum mod 2^WIDTH in every case.
